// File: rtl/dcache_write_rr_arbiter_if.sv
// Handshake/payload bundle between dcache write requesters and the data-array write arbiter.
// Requester payloads are packed, requester i occupying slice i.
interface dcache_write_rr_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int WAY_W   = 8,
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 128
);
  localparam int SRC_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic                      io_flush;
  logic [NUM_REQ-1:0]        io_in_valid;
  logic [NUM_REQ-1:0]        io_in_ready;
  logic [NUM_REQ*WAY_W-1:0]  io_in_way_en;
  logic [NUM_REQ*ADDR_W-1:0] io_in_addr;
  logic [NUM_REQ*DATA_W-1:0] io_in_data;
  logic                      io_out_valid;
  logic                      io_out_ready;
  logic [WAY_W-1:0]          io_out_way_en;
  logic [ADDR_W-1:0]         io_out_addr;
  logic [DATA_W-1:0]         io_out_data;
  logic [SRC_W-1:0]          io_out_src;

  modport master (
    output io_flush, io_in_valid, io_in_way_en, io_in_addr, io_in_data, io_out_ready,
    input  io_in_ready, io_out_valid, io_out_way_en, io_out_addr, io_out_data, io_out_src
  );

  modport slave (
    input  io_flush, io_in_valid, io_in_way_en, io_in_addr, io_in_data, io_out_ready,
    output io_in_ready, io_out_valid, io_out_way_en, io_out_addr, io_out_data, io_out_src
  );
endinterface

// File: rtl/dcache_write_rr_arbiter.sv
// Round-robin arbiter of dcache write requests onto one registered data-array write beat.
// Define DCACHE_WRITE_ARB_PERF_EN to add the saturating stall-cycle counter io_perf_stall_cnt.
module dcache_write_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WAY_W   = 8,
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 128
) (
  input  logic                     clock,
  input  logic                     reset,
  dcache_write_rr_arbiter_if.slave io
`ifdef DCACHE_WRITE_ARB_PERF_EN
  ,
  output logic [15:0]              io_perf_stall_cnt
`endif
);
  localparam int          SRC_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned N     = NUM_REQ;

  logic              r_out_valid;
  logic [WAY_W-1:0]  r_out_way_en;
  logic [ADDR_W-1:0] r_out_addr;
  logic [DATA_W-1:0] r_out_data;
  logic [SRC_W-1:0]  r_out_src;
  logic [SRC_W-1:0]  r_ptr;

  logic               w_can_accept;
  logic               w_found;
  logic               w_fire;
  logic [SRC_W-1:0]   w_grant_idx;
  logic [NUM_REQ-1:0] w_grant;
  logic [WAY_W-1:0]   w_way_arr  [NUM_REQ];
  logic [ADDR_W-1:0]  w_addr_arr [NUM_REQ];
  logic [DATA_W-1:0]  w_data_arr [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign w_way_arr[g]  = io.io_in_way_en[g*WAY_W +: WAY_W];
    assign w_addr_arr[g] = io.io_in_addr[g*ADDR_W +: ADDR_W];
    assign w_data_arr[g] = io.io_in_data[g*DATA_W +: DATA_W];
  end

  assign w_can_accept = (~r_out_valid | io.io_out_ready) & ~io.io_flush;

  // Search starts one past the last winner and wraps, so the last winner ranks lowest.
  always_comb begin
    int unsigned      sum;
    logic [SRC_W-1:0] idx;
    w_found     = 1'b0;
    w_grant_idx = '0;
    w_grant     = '0;
    for (int unsigned k = 0; k < N; k++) begin
      sum = 32'(r_ptr) + k + 1;
      if (sum >= N) sum = sum - N;
      idx = sum[SRC_W-1:0];
      if (!w_found && io.io_in_valid[idx]) begin
        w_found     = 1'b1;
        w_grant_idx = idx;
      end
    end
    w_grant[w_grant_idx] = w_found;
  end

  assign w_fire         = w_found & w_can_accept;
  assign io.io_in_ready = w_can_accept ? w_grant : '0;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_out_valid  <= 1'b0;
      r_out_way_en <= '0;
      r_out_addr   <= '0;
      r_out_data   <= '0;
      r_out_src    <= '0;
      r_ptr        <= SRC_W'(NUM_REQ - 1);
    end else if (w_fire) begin
      r_out_valid  <= 1'b1;
      r_out_way_en <= w_way_arr[w_grant_idx];
      r_out_addr   <= w_addr_arr[w_grant_idx];
      r_out_data   <= w_data_arr[w_grant_idx];
      r_out_src    <= w_grant_idx;
      r_ptr        <= w_grant_idx;
    end else if (io.io_flush | io.io_out_ready) begin
      r_out_valid  <= 1'b0;
    end
  end

`ifdef DCACHE_WRITE_ARB_PERF_EN
  logic [15:0] r_perf_stall_cnt;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_perf_stall_cnt <= '0;
    end else if (r_out_valid && !io.io_out_ready && (r_perf_stall_cnt != '1)) begin
      r_perf_stall_cnt <= r_perf_stall_cnt + 16'd1;
    end
  end

  assign io_perf_stall_cnt = r_perf_stall_cnt;
`endif

  assign io.io_out_valid  = r_out_valid;
  assign io.io_out_way_en = r_out_way_en;
  assign io.io_out_addr   = r_out_addr;
  assign io.io_out_data   = r_out_data;
  assign io.io_out_src    = r_out_src;
endmodule

// File: tb/tb_dcache_write_rr_arbiter.sv
// Randomized self-checking bench for dcache_write_rr_arbiter against a behavioural model.
// Define DCACHE_WRITE_ARB_PERF_EN to also exercise the stall counter.
module tb_dcache_write_rr_arbiter;
  localparam int NR = 4;
  localparam int WW = 8;
  localparam int AW = 12;
  localparam int DW = 128;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   vecs  = 0;
  int   errs  = 0;

  dcache_write_rr_arbiter_if #(.NUM_REQ(NR), .WAY_W(WW), .ADDR_W(AW), .DATA_W(DW)) bus ();

`ifdef DCACHE_WRITE_ARB_PERF_EN
  logic [15:0] perf_cnt;
  logic [15:0] m_perf;
`endif

  dcache_write_rr_arbiter #(.NUM_REQ(NR), .WAY_W(WW), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clock (clock),
    .reset (reset),
    .io    (bus)
`ifdef DCACHE_WRITE_ARB_PERF_EN
    ,
    .io_perf_stall_cnt (perf_cnt)
`endif
  );

  always #5 clock = ~clock;

  // Reference model: last winner, and the beat currently presented to the data array.
  int          m_ptr;
  bit          m_valid;
  int          m_src;
  logic [AW-1:0] m_addr;
  logic [WW-1:0] m_way;
  logic [DW-1:0] m_data;

  function automatic int winner();
    for (int k = 1; k <= NR; k++)
      if (bus.io_in_valid[(m_ptr + k) % NR]) return (m_ptr + k) % NR;
    return -1;
  endfunction

  function automatic logic [NR-1:0] exp_ready();
    logic [NR-1:0] r = '0;
    int w = winner();
    if ((!m_valid || bus.io_out_ready) && !bus.io_flush && w >= 0) r[w] = 1'b1;
    return r;
  endfunction

  task automatic model_reset();
    m_ptr = NR - 1; m_valid = 0; m_src = 0; m_addr = '0; m_way = '0; m_data = '0;
`ifdef DCACHE_WRITE_ARB_PERF_EN
    m_perf = '0;
`endif
  endtask

  task automatic rand_payload();
    for (int i = 0; i < NR; i++) begin
      bus.io_in_addr[i*AW +: AW] = AW'($urandom);
      bus.io_in_way_en[i*WW +: WW] = WW'($urandom);
      bus.io_in_data[i*DW +: DW] = {$urandom, $urandom, $urandom, $urandom};
    end
  endtask

  // Applies one clock edge to both DUT and model, returning 1 time unit after the edge.
  task automatic advance();
    int w = winner();
    bit fire = (!m_valid || bus.io_out_ready) && !bus.io_flush && (w >= 0);
    bit drain = bus.io_flush || bus.io_out_ready;
    logic [AW-1:0] a = '0;
    logic [WW-1:0] wy = '0;
    logic [DW-1:0] d = '0;
    if (w >= 0) begin
      a = bus.io_in_addr[w*AW +: AW]; wy = bus.io_in_way_en[w*WW +: WW]; d = bus.io_in_data[w*DW +: DW];
    end
`ifdef DCACHE_WRITE_ARB_PERF_EN
    if (m_valid && !bus.io_out_ready && m_perf != 16'hFFFF) m_perf = m_perf + 16'd1;
`endif
    @(posedge clock);
    if (fire) begin
      m_valid = 1; m_src = w; m_ptr = w; m_addr = a; m_way = wy; m_data = d;
    end else if (drain) begin
      m_valid = 0;
    end
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus.io_flush = 0; bus.io_in_valid = '0; bus.io_out_ready = 0;
    rand_payload();
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    vecs++; if (bus.io_out_valid !== 1'b0) begin errs++; $display("FAIL reset_valid got=%b exp=0", bus.io_out_valid); end
    vecs++; if (bus.io_out_addr !== '0 || bus.io_out_way_en !== '0) begin errs++; $display("FAIL reset_addr_way got=%h/%h exp=0/0", bus.io_out_addr, bus.io_out_way_en); end
    vecs++; if (bus.io_out_data !== '0 || bus.io_out_src !== '0) begin errs++; $display("FAIL reset_data_src got=%h/%0d exp=0/0", bus.io_out_data, bus.io_out_src); end
`ifdef DCACHE_WRITE_ARB_PERF_EN
    vecs++; if (perf_cnt !== 16'd0) begin errs++; $display("FAIL reset_perf got=%0d exp=0", perf_cnt); end
`endif
    @(negedge clock);
    reset = 1'b1;
    #1;
  endtask

  task automatic test_rr_all_valid();
    logic [NR-1:0] oh;
    bus.io_in_valid = '1; bus.io_out_ready = 1;
    for (int k = 0; k < 5; k++) begin
      rand_payload();
      #1;
      oh = '0; oh[k % NR] = 1'b1;
      vecs++; if (bus.io_in_ready !== oh || bus.io_in_ready !== exp_ready()) begin
        errs++; $display("FAIL rr_ready k=%0d got=%b exp=%b", k, bus.io_in_ready, oh);
      end
      advance();
      vecs++; if (bus.io_out_valid !== 1'b1 || bus.io_out_src !== 2'(k % NR) || bus.io_out_data !== m_data) begin
        errs++; $display("FAIL rr_out k=%0d got v=%b src=%0d exp v=1 src=%0d", k, bus.io_out_valid, bus.io_out_src, k % NR);
      end
    end
  endtask

  task automatic test_single_req2();
    bus.io_in_valid = 4'b0100; bus.io_out_ready = 1;
    rand_payload();
    bus.io_in_addr[2*AW +: AW] = 12'h0A5;
    bus.io_in_way_en[2*WW +: WW] = 8'h10;
    #1;
    vecs++; if (bus.io_in_ready !== 4'b0100) begin errs++; $display("FAIL single_ready got=%b exp=0100", bus.io_in_ready); end
    advance();
    vecs++; if (bus.io_out_valid !== 1'b1 || bus.io_out_addr !== 12'h0A5 || bus.io_out_way_en !== 8'h10 || bus.io_out_src !== 2'd2) begin
      errs++; $display("FAIL single_out got v=%b a=%h w=%h s=%0d exp v=1 a=0a5 w=10 s=2",
                       bus.io_out_valid, bus.io_out_addr, bus.io_out_way_en, bus.io_out_src);
    end
    bus.io_in_valid = '0;
    #1;
    vecs++; if (bus.io_in_ready !== '0) begin errs++; $display("FAIL idle_ready got=%b exp=0000", bus.io_in_ready); end
    advance();
    vecs++; if (bus.io_out_valid !== 1'b0) begin errs++; $display("FAIL drain_valid got=%b exp=0", bus.io_out_valid); end
  endtask

  task automatic test_stall();
    logic [AW-1:0] held_addr;
    logic [DW-1:0] held_data;
`ifdef DCACHE_WRITE_ARB_PERF_EN
    logic [15:0] perf_base;
`endif
    bus.io_in_valid = 4'b0010; bus.io_out_ready = 0;
    rand_payload();
    advance();
    held_addr = m_addr; held_data = m_data;
`ifdef DCACHE_WRITE_ARB_PERF_EN
    perf_base = m_perf;
`endif
    vecs++; if (bus.io_out_valid !== 1'b1 || bus.io_out_src !== 2'd1) begin errs++; $display("FAIL stall_load got v=%b s=%0d exp v=1 s=1", bus.io_out_valid, bus.io_out_src); end
    for (int k = 0; k < 5; k++) begin
      rand_payload();
      #1;
      vecs++; if (bus.io_in_ready !== '0) begin errs++; $display("FAIL stall_ready k=%0d got=%b exp=0000", k, bus.io_in_ready); end
      advance();
      vecs++; if (bus.io_out_valid !== 1'b1 || bus.io_out_addr !== held_addr || bus.io_out_data !== held_data || bus.io_out_src !== 2'd1) begin
        errs++; $display("FAIL stall_hold k=%0d got a=%h s=%0d exp a=%h s=1", k, bus.io_out_addr, bus.io_out_src, held_addr);
      end
    end
`ifdef DCACHE_WRITE_ARB_PERF_EN
    vecs++; if (perf_cnt !== perf_base + 16'd5) begin errs++; $display("FAIL stall_perf got=%0d exp=%0d", perf_cnt, perf_base + 16'd5); end
`endif
    bus.io_in_valid = '0; bus.io_out_ready = 1;
    advance();
  endtask

  task automatic test_flush();
    bus.io_in_valid = 4'b0001; bus.io_out_ready = 0;
    advance();
    bus.io_flush = 1; bus.io_out_ready = 1; bus.io_in_valid = 4'b1111;
    #1;
    vecs++; if (bus.io_in_ready !== '0) begin errs++; $display("FAIL flush_ready got=%b exp=0000", bus.io_in_ready); end
    advance();
    vecs++; if (bus.io_out_valid !== 1'b0) begin errs++; $display("FAIL flush_valid got=%b exp=0", bus.io_out_valid); end
    bus.io_flush = 0;
    #1;
    vecs++; if (bus.io_in_ready !== 4'b0010) begin errs++; $display("FAIL flush_ptr got=%b exp=0010", bus.io_in_ready); end
    advance();
  endtask

  task automatic test_reset_stall();
    bus.io_in_valid = '0; bus.io_out_ready = 0;
    advance();
    vecs++; if (bus.io_out_valid !== 1'b1) begin errs++; $display("FAIL rst_stall_setup got=%b exp=1", bus.io_out_valid); end
    reset = 1'b0;
    model_reset();
    #1;
    vecs++; if (bus.io_out_valid !== 1'b0 || bus.io_out_src !== '0) begin errs++; $display("FAIL rst_async got v=%b s=%0d exp v=0 s=0", bus.io_out_valid, bus.io_out_src); end
    @(negedge clock);
    reset = 1'b1;
    bus.io_in_valid = '1; bus.io_out_ready = 1;
    #1;
    vecs++; if (bus.io_in_ready !== 4'b0001) begin errs++; $display("FAIL rst_first_grant got=%b exp=0001", bus.io_in_ready); end
    advance();
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      bus.io_in_valid = NR'($urandom);
      bus.io_out_ready = ($urandom % 4) != 0;
      bus.io_flush = ($urandom % 10) == 0;
      rand_payload();
      #1;
      vecs++; if (bus.io_in_ready !== exp_ready()) begin errs++; $display("FAIL rand_ready n=%0d got=%b exp=%b", n, bus.io_in_ready, exp_ready()); end
      advance();
      vecs++; if (bus.io_out_valid !== m_valid) begin errs++; $display("FAIL rand_valid n=%0d got=%b exp=%b", n, bus.io_out_valid, m_valid); end
      if (m_valid) begin
        vecs++; if (bus.io_out_src !== 2'(m_src) || bus.io_out_addr !== m_addr || bus.io_out_way_en !== m_way || bus.io_out_data !== m_data) begin
          errs++; $display("FAIL rand_beat n=%0d got s=%0d a=%h w=%h exp s=%0d a=%h w=%h", n, bus.io_out_src, bus.io_out_addr, bus.io_out_way_en, m_src, m_addr, m_way);
        end
      end
`ifdef DCACHE_WRITE_ARB_PERF_EN
      vecs++; if (perf_cnt !== m_perf) begin errs++; $display("FAIL rand_perf n=%0d got=%0d exp=%0d", n, perf_cnt, m_perf); end
`endif
    end
    bus.io_flush = 0;
  endtask

`ifdef DCACHE_WRITE_ARB_PERF_EN
  task automatic test_perf_saturate();
    bus.io_in_valid = 4'b0001; bus.io_out_ready = 0;
    advance();
    bus.io_in_valid = '0;
    repeat (70000) advance();
    vecs++; if (perf_cnt !== 16'hFFFF || m_perf !== 16'hFFFF) begin errs++; $display("FAIL perf_sat got=%h exp=ffff", perf_cnt); end
    vecs++; if (bus.io_out_valid !== 1'b1) begin errs++; $display("FAIL perf_sat_valid got=%b exp=1", bus.io_out_valid); end
  endtask
`endif

  initial begin
    test_reset();
    test_rr_all_valid();
    test_single_req2();
    test_stall();
    test_flush();
    test_reset_stall();
    test_random();
`ifdef DCACHE_WRITE_ARB_PERF_EN
    test_perf_saturate();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/dcache_write_rr_arbiter.md
DCACHE_WRITE_RR_ARBITER -- requirements
Module: dcache_write_rr_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters (2..8).
REQ-002 SHALL have parameter WAY_W, default 8, way-enable width.
REQ-003 SHALL have parameter ADDR_W, default 12, data-array row address width.
REQ-004 SHALL have parameter DATA_W, default 128, write data width.
REQ-005 SHALL have port `clock`, input, 1, sole clock; all state on rising edge.
REQ-006 SHALL have port `reset`, input, 1, asynchronous, active-low reset (0 = in reset).
REQ-007 SHALL have port `io_flush`, input, 1, synchronous drop of the registered output beat.
REQ-008 SHALL have port `io_in_valid`, input, NUM_REQ, per-requester request valid.
REQ-009 SHALL have port `io_in_ready`, output, NUM_REQ, per-requester accept.
REQ-010 SHALL have ports `io_in_way_en` / `io_in_addr` / `io_in_data`, input, NUM_REQ×WAY_W / ×ADDR_W / ×DATA_W, packed per-requester payload, requester i at slice i.
REQ-011 SHALL have port `io_out_valid`, output, 1, registered beat valid toward data array.
REQ-012 SHALL have port `io_out_ready`, input, 1, data array accepts beat.
REQ-013 SHALL have ports `io_out_way_en`, `io_out_addr`, `io_out_data`, output, WAY_W/ADDR_W/DATA_W, registered payload.
REQ-014 SHALL have port `io_out_src`, output, clog2(NUM_REQ), index of requester that produced the current beat.

Function
REQ-015 SHALL grant round-robin: search starts at (ptr+1) mod NUM_REQ, first valid requester in ascending-wrap order wins.
REQ-016 SHALL compute grant combinationally from `io_in_valid` and ptr; at most one `io_in_ready` bit high per cycle.
REQ-017 SHALL define can_accept = (~io_out_valid | io_out_ready) & ~io_flush.
REQ-018 SHALL drive io_in_ready[i] = can_accept & grant[i]; io_in_ready SHALL NOT depend on io_in_valid[i] of non-granted requesters beyond priority search.
REQ-019 SHALL, on input fire (valid & ready), load out registers with granted payload and src, set io_out_valid=1 next cycle: latency exactly 1 cycle.
REQ-020 SHALL update ptr to granted index only on input fire; no fire leaves ptr unchanged.
REQ-021 SHALL clear io_out_valid when io_out_ready=1 and no input fires that cycle.
REQ-022 SHALL sustain one beat per cycle when io_out_ready held high (back-to-back fire and drain same cycle).
REQ-023 SHALL hold out payload and src stable while io_out_valid=1 and io_out_ready=0.
REQ-024 SHALL, when io_flush=1, clear io_out_valid next cycle, accept no input that cycle, retain ptr; flush overrides simultaneous out handshake and input fire.
REQ-025 SHALL guarantee any continuously valid requester is granted within NUM_REQ-1 other input fires.
REQ-026 SHALL, with no valid requester, keep all io_in_ready low and ptr unchanged.

Reset
REQ-027 SHALL, while `reset`=0, force io_out_valid=0, io_out_way_en/addr/data=0, io_out_src=0, ptr=NUM_REQ-1 (requester 0 highest priority first).
REQ-028 SHALL apply reset asynchronously on assertion; deassertion mid-stall discards the held beat with no replay.

Configuration
REQ-029 SHALL, with macro DCACHE_WRITE_ARB_PERF_EN defined, add output `io_perf_stall_cnt` [15:0], counting cycles with io_out_valid=1 & io_out_ready=0, saturating at 0xFFFF, reset to 0, unaffected by flush.
REQ-030 SHALL, without DCACHE_WRITE_ARB_PERF_EN, omit the port and counter entirely; all other behaviour identical.

Verification
REQ-031 SHALL cover: reset, all 4 valid, out_ready=1 -> grants 0,1,2,3,0 on consecutive cycles, io_out_src follows one cycle later.
REQ-032 SHALL cover: only req 2 valid, addr=0x0A5, way_en=0x10 -> io_out_valid=1 next cycle with addr 0x0A5, way_en 0x10, src 2.
REQ-033 SHALL cover: out_valid=1, out_ready=0 for 5 cycles, req 1 valid -> io_in_ready=0, payload held, perf count +5 when PERF_EN.
REQ-034 SHALL cover: io_flush=1 with out_valid=1, out_ready=1, req 0 valid -> no input fire, io_out_valid=0 next cycle, ptr unchanged.
REQ-035 SHALL cover: reset asserted during stalled beat -> io_out_valid=0 immediately, next grant goes to req 0.
REQ-036 SHALL cover: stall held 70000 cycles with PERF_EN -> io_perf_stall_cnt saturates at 0xFFFF.
